// File: rtl/mem_dump_tx.sv
// mem_dump_tx: reads a range of 16-bit words from memory and streams them to a
// UART transmitter, high byte first. It can optionally append the 0x7f,0xff
// terminator so that a peer running the program-loader protocol can accept the
// stream. The block owns the memory read port while busy is high.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_IDLE      | waiting for start; clears busy one cycle after done
//   S_RD        | rd_mem high, mem_addr = current word address
//   S_LATCH     | capture rd_data into the word register, flag 0x7fff words
//   S_HI        | wait for tx_ready, then send word[15:8]
//   S_HI_GAP    | skip one cycle while the UART drops tx_ready
//   S_LO        | wait for tx_ready, then send word[7:0]
//   S_LO_GAP    | advance address/count, choose next word or terminator
//   S_TERM_HI   | wait for tx_ready, then send 0x7f
//   S_TERM_GAP  | skip one cycle while the UART drops tx_ready
//   S_TERM_LO   | wait for tx_ready, then send 0xff
//   S_TERM_GAP2 | skip one cycle before finishing
//   S_DONE      | raise the one-cycle done pulse
module mem_dump_tx #(
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 10,
  parameter bit SEND_TERM = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rd_mem,
  input  logic [15:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              term_clash
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_LATCH,
    S_HI,
    S_HI_GAP,
    S_LO,
    S_LO_GAP,
    S_TERM_HI,
    S_TERM_GAP,
    S_TERM_LO,
    S_TERM_GAP2,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_remaining;
  logic [15:0]         r_word;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_rd_mem;
  logic [7:0]          r_tx_data;
  logic                r_tx_wr;
  logic                r_busy;
  logic                r_done;
  logic                r_term_clash;

  logic [ADDR_W-1:0]   w_start_even;
  logic [ADDR_W-1:0]   w_next_addr;

  // Words are always fetched from even byte addresses; the increment wraps silently.
  assign w_start_even = start_addr & ~ADDR_W'(1);
  assign w_next_addr  = r_addr + ADDR_W'(2);

  assign mem_addr   = r_mem_addr;
  assign rd_mem     = r_rd_mem;
  assign tx_data    = r_tx_data;
  assign tx_wr      = r_tx_wr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign term_clash = r_term_clash;

  // Sequencer: all outputs are registered, so rd_mem/mem_addr are loaded on
  // the transition into S_RD and tx_wr is high during the following gap state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_word       <= '0;
      r_mem_addr   <= '0;
      r_rd_mem     <= 1'b0;
      r_tx_data    <= '0;
      r_tx_wr      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_term_clash <= 1'b0;
    end else begin
      r_rd_mem <= 1'b0;
      r_tx_wr  <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy stays up through the cycle that shows done, then drops
          r_busy <= 1'b0;
          if (start) begin
            r_busy       <= 1'b1;
            r_addr       <= w_start_even;
            r_remaining  <= word_count;
            r_term_clash <= 1'b0;
            if (word_count != '0) begin
              r_state    <= S_RD;
              r_rd_mem   <= 1'b1;
              r_mem_addr <= w_start_even;
            end else if (SEND_TERM) begin
              r_state <= S_TERM_HI;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_RD: r_state <= S_LATCH;
        S_LATCH: begin
          r_word <= rd_data;
          if (rd_data == 16'h7fff) r_term_clash <= 1'b1;
          r_state <= S_HI;
        end
        S_HI: begin
          if (tx_ready) begin
            r_tx_data <= r_word[15:8];
            r_tx_wr   <= 1'b1;
            r_state   <= S_HI_GAP;
          end
        end
        S_HI_GAP: r_state <= S_LO;
        S_LO: begin
          if (tx_ready) begin
            r_tx_data <= r_word[7:0];
            r_tx_wr   <= 1'b1;
            r_state   <= S_LO_GAP;
          end
        end
        S_LO_GAP: begin
          r_addr      <= w_next_addr;
          r_remaining <= r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            if (SEND_TERM) r_state <= S_TERM_HI;
            else           r_state <= S_DONE;
          end else begin
            r_state    <= S_RD;
            r_rd_mem   <= 1'b1;
            r_mem_addr <= w_next_addr;
          end
        end
        S_TERM_HI: begin
          if (tx_ready) begin
            r_tx_data <= 8'h7f;
            r_tx_wr   <= 1'b1;
            r_state   <= S_TERM_GAP;
          end
        end
        S_TERM_GAP: r_state <= S_TERM_LO;
        S_TERM_LO: begin
          if (tx_ready) begin
            r_tx_data <= 8'hff;
            r_tx_wr   <= 1'b1;
            r_state   <= S_TERM_GAP2;
          end
        end
        S_TERM_GAP2: r_state <= S_DONE;
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: a memory model, a UART model with optional
// backpressure, and a linear sequence of directed dumps with fixed expectations.
module tb_mem_dump_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        start0;
  logic [9:0]  start_addr;
  logic [9:0]  word_count;
  logic [9:0]  mem_addr;
  logic        rd_mem;
  logic [15:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        term_clash;

  logic [9:0]  mem_addr0;
  logic        rd_mem0;
  logic [15:0] rd_data0 = 16'h0000;
  logic [7:0]  tx_data0;
  logic        tx_wr0;
  logic        busy0;
  logic        done0;
  logic        term_clash0;

  logic [15:0] mem [0:1023];
  logic [7:0]  bytes[$];
  logic [9:0]  rd_log[$];
  int          viol = 0;
  int          done_cnt = 0;
  int          tx_cnt0 = 0;
  int          rd_cnt0 = 0;
  logic        prev_wr = 1'b0;
  bit          bp = 1'b0;
  int          bp_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign tx_ready = (bp_cnt == 0);

  mem_dump_tx #(.ADDR_W(10), .CNT_W(10), .SEND_TERM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .mem_addr(mem_addr), .rd_mem(rd_mem),
    .rd_data(rd_data), .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
    .busy(busy), .done(done), .term_clash(term_clash)
  );

  mem_dump_tx #(.ADDR_W(10), .CNT_W(10), .SEND_TERM(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .start_addr(start_addr),
    .word_count(word_count), .mem_addr(mem_addr0), .rd_mem(rd_mem0),
    .rd_data(rd_data0), .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_ready(tx_ready),
    .busy(busy0), .done(done0), .term_clash(term_clash0)
  );

  // Memory with one-cycle read latency, UART with optional 20-cycle ready drop,
  // and logging of reads, bytes, done pulses and handshake violations.
  always @(posedge clk) begin
    if (rd_mem) begin
      rd_data <= mem[mem_addr];
      rd_log.push_back(mem_addr);
    end
    if (tx_wr) begin
      bytes.push_back(tx_data);
      if (!tx_ready || prev_wr) viol <= viol + 1;
    end
    prev_wr <= tx_wr;
    if (done) done_cnt <= done_cnt + 1;
    if (tx_wr && bp) bp_cnt <= 20;
    else if (bp_cnt > 0) bp_cnt <= bp_cnt - 1;
    if (tx_wr0) tx_cnt0 <= tx_cnt0 + 1;
    if (rd_mem0) rd_cnt0 <= rd_cnt0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] e[$]);
    int n;
    n = bytes.size() - base;
    check($sformatf("%s_nbytes", tag), n, e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < n) check($sformatf("%s_byte%0d", tag, i), {24'h0, bytes[base+i]}, {24'h0, e[i]});
    end
  endtask

  // Returns at the negedge just after the accepting clock edge.
  task automatic pulse_start(input logic [9:0] a, input logic [9:0] n);
    @(negedge clk);
    start_addr = a;
    word_count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    logic [7:0] e[$];
    int b0, r0, d0, cyc;

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h300] = 16'h1234;
    mem[10'h302] = 16'habcd;
    mem[10'h100] = 16'h7fff;
    mem[10'h3fe] = 16'h5a5a;
    mem[10'h000] = 16'hc33c;
    mem[10'h200] = 16'h0102;
    mem[10'h202] = 16'h0304;
    mem[10'h204] = 16'h0506;
    mem[10'h206] = 16'h0708;

    rst_n = 1'b0;
    start = 1'b0;
    start0 = 1'b0;
    start_addr = '0;
    word_count = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rd_mem", rd_mem, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_term_clash", term_clash, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-word dump with terminator, tx_ready held high.
    b0 = bytes.size(); r0 = rd_log.size(); d0 = done_cnt;
    pulse_start(10'h300, 10'd2);
    check("basic_busy_after_start", busy, 1);
    wait_done(100, cyc);
    check("basic_done_seen", done, 1);
    check("basic_cycles", cyc, 17);
    check("basic_busy_at_done", busy, 1);
    @(negedge clk);
    check("basic_busy_after_done", busy, 0);
    check("basic_done_one_cycle", done, 0);
    e = '{8'h12, 8'h34, 8'hab, 8'hcd, 8'h7f, 8'hff};
    check_bytes("basic", b0, e);
    check("basic_nreads", rd_log.size() - r0, 2);
    if (rd_log.size() - r0 == 2) begin
      check("basic_read0", rd_log[r0], 10'h300);
      check("basic_read1", rd_log[r0+1], 10'h302);
    end
    check("basic_done_count", done_cnt - d0, 1);
    check("basic_no_clash", term_clash, 0);

    // Same dump with a 20-cycle ready drop after every byte.
    bp = 1'b1;
    b0 = bytes.size(); d0 = done_cnt;
    pulse_start(10'h300, 10'd2);
    wait_done(600, cyc);
    check("bp_done_seen", done, 1);
    @(negedge clk);
    e = '{8'h12, 8'h34, 8'hab, 8'hcd, 8'h7f, 8'hff};
    check_bytes("bp", b0, e);
    check("bp_handshake_viol", viol, 0);
    check("bp_done_count", done_cnt - d0, 1);
    bp = 1'b0;
    repeat (25) @(negedge clk);

    // Odd start address and a word equal to the terminator.
    b0 = bytes.size(); r0 = rd_log.size();
    pulse_start(10'h101, 10'd1);
    wait_done(100, cyc);
    check("clash_done_seen", done, 1);
    @(negedge clk);
    e = '{8'h7f, 8'hff, 8'h7f, 8'hff};
    check_bytes("clash", b0, e);
    check("clash_nreads", rd_log.size() - r0, 1);
    if (rd_log.size() - r0 == 1) check("clash_read_even", rd_log[r0], 10'h100);
    check("clash_flag", term_clash, 1);
    repeat (5) @(negedge clk);
    check("clash_flag_sticky", term_clash, 1);

    // Zero count with terminator: only 7f,ff and no reads; also clears the clash flag.
    b0 = bytes.size(); r0 = rd_log.size();
    pulse_start(10'h040, 10'd0);
    check("zero_clash_cleared", term_clash, 0);
    wait_done(100, cyc);
    check("zero_done_seen", done, 1);
    check("zero_cycles", cyc, 5);
    @(negedge clk);
    e = '{8'h7f, 8'hff};
    check_bytes("zero", b0, e);
    check("zero_nreads", rd_log.size() - r0, 0);

    // Zero count without terminator: done shows two cycles after the start cycle.
    @(negedge clk);
    word_count = 10'd0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("zero0_done_seen", done0, 1);
    check("zero0_cycles", cyc, 1);
    @(negedge clk);
    check("zero0_busy_after_done", busy0, 0);
    check("zero0_no_tx", tx_cnt0, 0);
    check("zero0_no_reads", rd_cnt0, 0);

    // Address wrap at the top of memory.
    b0 = bytes.size(); r0 = rd_log.size();
    pulse_start(10'h3fe, 10'd2);
    wait_done(100, cyc);
    check("wrap_done_seen", done, 1);
    @(negedge clk);
    e = '{8'h5a, 8'h5a, 8'hc3, 8'h3c, 8'h7f, 8'hff};
    check_bytes("wrap", b0, e);
    check("wrap_nreads", rd_log.size() - r0, 2);
    if (rd_log.size() - r0 == 2) begin
      check("wrap_read0", rd_log[r0], 10'h3fe);
      check("wrap_read1", rd_log[r0+1], 10'h000);
    end

    // A start pulse during a dump must be ignored.
    b0 = bytes.size(); r0 = rd_log.size(); d0 = done_cnt;
    pulse_start(10'h200, 10'd4);
    repeat (5) @(negedge clk);
    start_addr = 10'h100;
    word_count = 10'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, cyc);
    check("sib_done_seen", done, 1);
    @(negedge clk);
    e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h7f, 8'hff};
    check_bytes("sib", b0, e);
    check("sib_nreads", rd_log.size() - r0, 4);
    check("sib_done_count", done_cnt - d0, 1);
    check("sib_busy_after", busy, 0);

    // Reset right after the first byte of a 4-word dump aborts it.
    b0 = bytes.size(); r0 = rd_log.size();
    pulse_start(10'h200, 10'd4);
    cyc = 0;
    while (bytes.size() == b0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmid_first_byte_count", bytes.size() - b0, 1);
    if (bytes.size() > b0) check("rstmid_first_byte", {24'h0, bytes[b0]}, 32'h01);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_outputs_zero", {mem_addr, rd_mem, tx_data, tx_wr, busy, done, term_clash}, 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("rstmid_no_more_bytes", bytes.size() - b0, 1);
    check("rstmid_no_more_reads", rd_log.size() - r0, 1);
    check("rstmid_idle", busy, 0);
    check("rstmid_handshake_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
Name: mem_dump_tx

Overview:
- UART memory dumper; the transmit-side counterpart of the MCU program loader.
- On a start pulse it reads a range of 16-bit words from memory and sends each word as two bytes, high byte first, through the UART transmitter.
- Optionally appends the 0x7fff terminator, so a peer running the same loader protocol can receive the stream.
- Sits beside the CPU; it owns the memory read port while busy (the MCU muxes mem_addr on busy).

Parameters:
- ADDR_W, 10, memory byte-address width.
- CNT_W, 10, width of the word-count input.
- SEND_TERM, 1, when 1 append terminator bytes 0x7f, 0xff after the last word.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- start_addr  input  ADDR_W  byte address of the first word; bit 0 is ignored (forced 0).
- word_count  input  CNT_W  number of words to send.
- mem_addr  output  ADDR_W  memory read address.
- rd_mem  output  1  read strobe.
- rd_data  input  16  read data, valid exactly one cycle after rd_mem.
- tx_data  output  8  byte to the UART.
- tx_wr  output  1  one-cycle write pulse to the UART.
- tx_ready  input  1  UART transmitter idle.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse at completion.
- term_clash  output  1  sticky; set if any sent data word equals 16'h7fff.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; mem_addr=0, rd_mem=0, tx_data=0, tx_wr=0, busy=0, done=0, term_clash=0.
  - Reset mid-operation aborts the transfer immediately; no further bytes are sent.
- Registers: addr (ADDR_W), remaining (CNT_W), word (16).
- All outputs are registered.

States:
- IDLE:
  - On start=1: addr<={start_addr[ADDR_W-1:1],1'b0}; remaining<=word_count; term_clash<=0.
  - Next state: RD if word_count!=0; else TERM_HI if SEND_TERM; else DONE.
  - start while not IDLE is ignored.
- RD: rd_mem=1 and mem_addr=addr for exactly one cycle. Next state: LATCH.
- LATCH:
  - word<=rd_data (data from the previous cycle's read).
  - If rd_data==16'h7fff, term_clash<=1. The word is still sent; there is no escaping.
  - Next state: HI.
- HI: wait for tx_ready=1, then tx_data<=word[15:8], tx_wr=1 for one cycle. Next state: HI_GAP.
- HI_GAP: one cycle; tx_ready is ignored, covering the UART's 1-cycle ready-drop latency. Next state: LO.
- LO: wait for tx_ready, then send word[7:0]. Next state: LO_GAP.
- LO_GAP:
  - addr<=addr+2, wrapping modulo 2^ADDR_W.
  - remaining<=remaining-1.
  - If remaining==1: next state TERM_HI if SEND_TERM, else DONE. Otherwise next state RD.
- TERM_HI: wait for tx_ready, send 0x7f. Next state: TERM_GAP.
- TERM_GAP: one cycle. Next state: TERM_LO.
- TERM_LO: wait for tx_ready, send 0xff. Next state: TERM_GAP2.
- TERM_GAP2: one cycle. Next state: DONE.
- DONE: done=1 for one cycle, busy deasserts the following cycle. Next state: IDLE.

Handshake and timing rules:
- tx_wr is never asserted on two consecutive cycles, and never while tx_ready=0.
- Byte order is always high byte then low byte; the terminator follows the last low byte.
- Minimum per-word cycles with tx_ready held 1: RD, LATCH, HI, HI_GAP, LO, LO_GAP = 6.
- busy stays 1 from the cycle after start is accepted through the DONE cycle.
- rd_mem is 0 in every state except RD; mem_addr holds its last value.
- tx_ready stuck low: the FSM waits indefinitely in HI/LO/TERM_*; no timeout.
- word_count of all-ones: sends 2^CNT_W-1 words; the address wrap at the top of memory is silent.

Test Plan:
- Basic dump: mem[0x300]=0x1234, mem[0x302]=0xabcd; start_addr=0x300, word_count=2, tx_ready=1 -> tx bytes 12,34,ab,cd,7f,ff in order; reads at 0x300 then 0x302; done once; busy low the cycle after done.
- Backpressure: same as the basic dump, with tx_ready dropping for 20 cycles after each tx_wr -> identical byte sequence; tx_wr never asserted while tx_ready=0; no duplicated bytes.
- Zero count: word_count=0, SEND_TERM=1 -> only 7f,ff sent, no rd_mem. Same with SEND_TERM=0 -> no tx_wr, done pulses 2 cycles after start.
- Clash and odd address: start_addr=0x101 (reads 0x100), mem[0x100]=0x7fff, word_count=1 -> bytes 7f,ff,7f,ff; term_clash=1 and stays set until the next start.
- Wrap: ADDR_W=10, start_addr=0x3fe, word_count=2 -> reads 0x3fe then 0x000.
- Reset and start-while-busy: rst_n=0 for one cycle after the first byte of a 4-word dump -> no further tx_wr, all outputs 0. A start pulse during a dump is ignored: the byte count equals the original request.
